double_op_unit: RTL

DOUBLE_OP_UNIT -- requirements
Module: double_op_unit

---
 rtl/double_op_unit.sv | 209 ++++++++++++++++++++
 1 files changed

// File: rtl/double_op_unit.sv
// MSP430-style double-operand ALU: single-cycle logic/arithmetic ops and a
// nibble-serial decimal adder, sequenced by a small IDLE/EXEC/DADD/DONE FSM.
module double_op_unit #(
    parameter int WIDTH = 16
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             Start,
    input  logic [3:0]       Opcode,
    input  logic             Bw,
    input  logic [WIDTH-1:0] Src,
    input  logic [WIDTH-1:0] Dst,
    input  logic [3:0]       Flags_in,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] Res,
    output logic             Wr_en,
    output logic [3:0]       Flags,
    output logic             Illegal
);

    localparam int CW = $clog2(WIDTH / 4) + 1;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        DADD,
        DONE
    } state_t;

    state_t             state_q;
    logic [3:0]         op_q;
    logic               bw_q;
    logic [WIDTH-1:0]   src_q;
    logic [WIDTH-1:0]   dst_q;
    logic [3:0]         fin_q;
    logic [WIDTH-1:0]   acc_q;
    logic               cy_q;
    logic [CW-1:0]      cnt_q;
    logic               done_q;
    logic               ill_q;
    logic               wr_q;
    logic [WIDTH-1:0]   res_q;
    logic [3:0]         flags_q;

    function automatic logic sgn(input logic [WIDTH-1:0] x, input logic b);
        return b ? x[7] : x[WIDTH-1];
    endfunction

    logic [WIDTH-1:0] in_mask;
    assign in_mask = Bw ? WIDTH'(8'hFF) : {WIDTH{1'b1}};

    // Single-cycle datapath for all non-decimal opcodes
    logic [WIDTH-1:0] mask;
    logic [WIDTH-1:0] b_x;
    logic             sub;
    logic             cin;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] ar;
    logic             a_c;
    logic             a_v;
    logic [3:0]       a_flags;
    logic [WIDTH-1:0] l_res;
    logic [WIDTH-1:0] ex_res;
    logic [3:0]       ex_flags;
    logic             ex_wr;
    logic             ex_ill;

    always_comb begin
        mask = bw_q ? WIDTH'(8'hFF) : {WIDTH{1'b1}};
        sub  = (op_q == 4'h7) || (op_q == 4'h8) || (op_q == 4'h9);
        b_x  = sub ? (~src_q & mask) : src_q;
        case (op_q)
            4'h6, 4'h7: cin = fin_q[0];
            4'h8, 4'h9: cin = 1'b1;
            default:    cin = 1'b0;
        endcase
        sum     = {1'b0, dst_q} + {1'b0, b_x} + (WIDTH + 1)'(cin);
        ar      = sum[WIDTH-1:0] & mask;
        a_c     = bw_q ? sum[8] : sum[WIDTH];
        a_v     = (sgn(dst_q, bw_q) == sgn(b_x, bw_q)) &&
                  (sgn(ar, bw_q) != sgn(dst_q, bw_q));
        a_flags = {a_v, sgn(ar, bw_q), ar == '0, a_c};

        l_res    = '0;
        ex_res   = '0;
        ex_flags = fin_q;
        ex_wr    = 1'b1;
        ex_ill   = 1'b0;
        case (op_q)
            4'h4: ex_res = src_q;
            4'h5, 4'h6, 4'h7, 4'h8: begin
                ex_res   = ar;
                ex_flags = a_flags;
            end
            4'h9: begin
                ex_res   = ar;
                ex_flags = a_flags;
                ex_wr    = 1'b0;
            end
            4'hB, 4'hF: begin
                l_res    = dst_q & src_q;
                ex_res   = l_res;
                ex_flags = {1'b0, sgn(l_res, bw_q), l_res == '0, l_res != '0};
                ex_wr    = (op_q == 4'hF);
            end
            4'hC: ex_res = dst_q & ~src_q & mask;
            4'hD: ex_res = dst_q | src_q;
            4'hE: begin
                l_res    = dst_q ^ src_q;
                ex_res   = l_res;
                ex_flags = {sgn(src_q, bw_q) & sgn(dst_q, bw_q),
                            sgn(l_res, bw_q), l_res == '0, l_res != '0};
            end
            default: begin
                ex_wr  = 1'b0;
                ex_ill = 1'b1;
            end
        endcase
    end

    // One BCD digit per clock; digits above 9 fall out of the same +6 adjust
    logic [WIDTH-1:0] d_sh;
    logic [WIDTH-1:0] s_sh;
    logic [4:0]       nib_s;
    logic             d_c;
    logic [3:0]       nib_r;
    logic [WIDTH-1:0] acc_d;
    logic [CW-1:0]    nib_last;
    logic             d_last;

    always_comb begin
        d_sh     = dst_q >> {cnt_q, 2'b00};
        s_sh     = src_q >> {cnt_q, 2'b00};
        nib_s    = {1'b0, d_sh[3:0]} + {1'b0, s_sh[3:0]} + 5'(cy_q);
        d_c      = nib_s > 5'd9;
        nib_r    = d_c ? (nib_s[3:0] + 4'd6) : nib_s[3:0];
        acc_d    = acc_q | (WIDTH'(nib_r) << {cnt_q, 2'b00});
        nib_last = bw_q ? CW'(1) : CW'(WIDTH / 4 - 1);
        d_last   = (cnt_q == nib_last);
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q <= IDLE;
            op_q    <= '0;
            bw_q    <= 1'b0;
            src_q   <= '0;
            dst_q   <= '0;
            fin_q   <= '0;
            acc_q   <= '0;
            cy_q    <= 1'b0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            ill_q   <= 1'b0;
            wr_q    <= 1'b0;
            res_q   <= '0;
            flags_q <= '0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    done_q  <= 1'b0;
                    ill_q   <= 1'b0;
                    state_q <= IDLE;
                    if (Start) begin
                        op_q    <= Opcode;
                        bw_q    <= Bw;
                        src_q   <= Src & in_mask;
                        dst_q   <= Dst & in_mask;
                        fin_q   <= Flags_in;
                        acc_q   <= '0;
                        cy_q    <= Flags_in[0];
                        cnt_q   <= '0;
                        state_q <= (Opcode == 4'hA) ? DADD : EXEC;
                    end
                end
                EXEC: begin
                    res_q   <= ex_res;
                    flags_q <= ex_flags;
                    wr_q    <= ex_wr;
                    ill_q   <= ex_ill;
                    done_q  <= 1'b1;
                    state_q <= DONE;
                end
                DADD: begin
                    acc_q <= acc_d;
                    cy_q  <= d_c;
                    cnt_q <= cnt_q + CW'(1);
                    if (d_last) begin
                        res_q   <= acc_d;
                        flags_q <= {1'b0, sgn(acc_d, bw_q), acc_d == '0, d_c};
                        wr_q    <= 1'b1;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign Busy    = (state_q == EXEC) || (state_q == DADD);
    assign Done    = done_q;
    assign Illegal = ill_q;
    assign Wr_en   = wr_q;
    assign Res     = res_q;
    assign Flags   = flags_q;

endmodule
